// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the execute stage: bit positions of the ID/EX and
// EX/MEM pipeline words, ALUOp codes, opcode/funct constants, the
// multiply/divide engine state encoding and small decode helpers.
package mips_pkg;

    // Pipeline word widths
    localparam int IDEX_W = 136;
    localparam int EXME_W = 75;

    // ID/EX word layout
    localparam int IDEX_INSTR_LSB = 0;
    localparam int IDEX_RS_LSB    = 32;
    localparam int IDEX_RT_LSB    = 64;
    localparam int IDEX_IMM_LSB   = 96;
    localparam int IDEX_CTRL_LSB  = 128;

    // Bit positions inside the 8-bit control byte
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_ALUSRC   = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_ALUOP_LSB = 3;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_REGDST   = 7;

    // EX/MEM word layout
    localparam int EX_RESULT_LSB = 0;
    localparam int EX_STORE_LSB  = 32;
    localparam int EX_WREG_LSB   = 64;
    localparam int EX_REGWRITE   = 69;
    localparam int EX_MEMTOREG   = 70;
    localparam int EX_MEMWRITE   = 71;
    localparam int EX_MEMREAD    = 72;
    localparam int EX_ZERO       = 73;
    localparam int EX_VALID      = 74;

    // ALUOp codes
    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10,
        ALU_ORI   = 2'b11
    } aluOp_t;

    // Opcode / funct constants
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] F_SLL    = 6'h00;
    localparam logic [5:0] F_SRL    = 6'h02;
    localparam logic [5:0] F_SRA    = 6'h03;
    localparam logic [5:0] F_MFHI   = 6'h10;
    localparam logic [5:0] F_MFLO   = 6'h12;
    localparam logic [5:0] F_MULT   = 6'h18;
    localparam logic [5:0] F_MULTU  = 6'h19;
    localparam logic [5:0] F_DIV    = 6'h1A;
    localparam logic [5:0] F_DIVU   = 6'h1B;
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_ADDU   = 6'h21;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_SUBU   = 6'h23;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    localparam logic [5:0] F_XOR    = 6'h26;
    localparam logic [5:0] F_NOR    = 6'h27;
    localparam logic [5:0] F_SLT    = 6'h2A;
    localparam logic [5:0] F_SLTU   = 6'h2B;

    // Multiply/divide engine states
    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV  = 2'b10
    } mdState_t;

    function automatic logic isMulDivFunct(input logic [5:0] funct);
        return (funct == F_MULT) || (funct == F_MULTU) ||
               (funct == F_DIV)  || (funct == F_DIVU);
    endfunction

    function automatic logic isMoveFromFunct(input logic [5:0] funct);
        return (funct == F_MFHI) || (funct == F_MFLO);
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// execute_stage_if
// Bundles the signals between the decode side and the execute stage.
//   IDEXReg  136  ID/EX pipeline word (decode -> execute)
//   EXMEReg   75  registered EX/MEM word (execute -> memory)
//   exStall    1  hold request back to fetch/decode
//   mdBusy     1  multiply/divide engine not idle
// master: the decode/pipeline side; slave: the execute stage.
interface execute_stage_if;
    import mips_pkg::*;

    logic [IDEX_W-1:0] IDEXReg;
    logic [EXME_W-1:0] EXMEReg;
    logic              exStall;
    logic              mdBusy;

    modport master (output IDEXReg, input EXMEReg, exStall, mdBusy);
    modport slave  (input IDEXReg, output EXMEReg, exStall, mdBusy);
endinterface

// File: rtl/execute_stage_muldiv_unit.sv
// muldiv_unit
// Iterative shift-add multiplier and restoring divider with HI/LO registers.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             accept a new operation (only honoured when idle)
//   isDiv, isSigned   operation select
//   opA, opB          rs / rt operands
//   hi, lo            result registers
//   busy              engine not idle
// Optional build macro MULDIV_EARLY_OUT_EN: multiply stops as soon as the
// remaining multiplier bits are all zero.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int MUL_ITERS = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        isDiv,
    input  logic        isSigned,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    mdState_t    state;
    logic [7:0]  count;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] divisor;
    logic        negQ;
    logic        negR;
    logic [31:0] hiReg;
    logic [31:0] loReg;
    logic        busyReg;

    // Signed operations run on magnitudes; the sign is applied at the end.
    logic [31:0] magA;
    logic [31:0] magB;
    assign magA = (isSigned && opA[31]) ? (32'd0 - opA) : opA;
    assign magB = (isSigned && opB[31]) ? (32'd0 - opB) : opB;

    // Multiply iteration
    logic [63:0] mulSum;
    logic [63:0] mulProd;
    logic        mulLast;
    assign mulSum  = mplier[0] ? (acc + mcand) : acc;
    assign mulProd = negQ ? (64'd0 - mulSum) : mulSum;
`ifdef MULDIV_EARLY_OUT_EN
    // Nothing left to add once the bits above the current one are clear.
    assign mulLast = (count == 8'd1) || (mplier[31:1] == 31'd0);
`else
    assign mulLast = (count == 8'd1);
`endif

    // Restoring divide iteration: shift in the next dividend bit, try to
    // subtract, keep the difference only if it did not go negative.
    logic [32:0] remShift;
    logic [32:0] divDiff;
    logic        divGe;
    logic [31:0] remNext;
    logic [31:0] quoNext;
    assign remShift = {rem, quo[31]};
    assign divDiff  = remShift - {1'b0, divisor};
    assign divGe    = ~divDiff[32];
    assign remNext  = divGe ? divDiff[31:0] : remShift[31:0];
    assign quoNext  = {quo[30:0], divGe};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= MD_IDLE;
            count   <= 8'd0;
            acc     <= 64'd0;
            mcand   <= 64'd0;
            mplier  <= 32'd0;
            rem     <= 32'd0;
            quo     <= 32'd0;
            divisor <= 32'd0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
            hiReg   <= 32'd0;
            loReg   <= 32'd0;
            busyReg <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        negQ    <= isSigned & (opA[31] ^ opB[31]);
                        negR    <= isSigned & opA[31];
                        busyReg <= 1'b1;
                        if (isDiv) begin
                            state   <= MD_DIV;
                            rem     <= 32'd0;
                            divisor <= magB;
                            if (opB == 32'd0) begin
                                // Raw rs is kept so it can be returned in HI.
                                quo   <= opA;
                                count <= 8'd1;
                            end else begin
                                quo   <= magA;
                                count <= DIV_ITERS[7:0];
                            end
                        end else begin
                            state  <= MD_MUL;
                            acc    <= 64'd0;
                            mcand  <= {32'd0, magA};
                            mplier <= magB;
                            count  <= MUL_ITERS[7:0];
                        end
                    end
                end
                MD_MUL: begin
                    acc    <= mulSum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count - 8'd1;
                    if (mulLast) begin
                        hiReg   <= mulProd[63:32];
                        loReg   <= mulProd[31:0];
                        state   <= MD_IDLE;
                        busyReg <= 1'b0;
                    end
                end
                MD_DIV: begin
                    if (divisor == 32'd0) begin
                        hiReg   <= quo;
                        loReg   <= 32'hFFFF_FFFF;
                        count   <= 8'd0;
                        state   <= MD_IDLE;
                        busyReg <= 1'b0;
                    end else begin
                        rem   <= remNext;
                        quo   <= quoNext;
                        count <= count - 8'd1;
                        if (count == 8'd1) begin
                            // Remainder follows the dividend's sign.
                            loReg   <= negQ ? (32'd0 - quoNext) : quoNext;
                            hiReg   <= negR ? (32'd0 - remNext) : remNext;
                            state   <= MD_IDLE;
                            busyReg <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= MD_IDLE;
                    busyReg <= 1'b0;
                end
            endcase
        end
    end

    assign hi   = hiReg;
    assign lo   = loReg;
    assign busy = busyReg;

endmodule

// File: rtl/execute_stage.sv
// execute_stage
// Consumer end of the ID/EX register: ALU, operand select, write-register
// select and the EX/MEM register, plus the multiply/divide engine.
// Ports:
//   clk   pipeline clock, rising edge
//   rst   asynchronous active-high reset
//   bus   execute_stage_if.slave: IDEXReg in; EXMEReg, exStall, mdBusy out
// Parameters: MUL_ITERS, DIV_ITERS (engine iteration counts).
// Optional build macro MULDIV_EARLY_OUT_EN enables multiply early-out in
// the engine.
module execute_stage
    import mips_pkg::*;
#(
    parameter int MUL_ITERS = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic            clk,
    input  logic            rst,
    execute_stage_if.slave  bus
);

    // ID/EX field extraction
    logic [7:0]  ctrl;
    logic [31:0] imm;
    logic [31:0] rtData;
    logic [31:0] rsData;
    logic [31:0] instr;
    assign ctrl   = bus.IDEXReg[IDEX_CTRL_LSB +: 8];
    assign imm    = bus.IDEXReg[IDEX_IMM_LSB +: 32];
    assign rtData = bus.IDEXReg[IDEX_RT_LSB +: 32];
    assign rsData = bus.IDEXReg[IDEX_RS_LSB +: 32];
    assign instr  = bus.IDEXReg[IDEX_INSTR_LSB +: 32];

    logic [1:0] aluOp;
    assign aluOp = ctrl[CTRL_ALUOP_LSB +: 2];

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] shamt;
    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    assign shamt  = instr[10:6];

    // The rs field of the instruction is not needed here (data arrives decoded).
    logic unusedRsField;
    assign unusedRsField = ^instr[25:21];

    // HI/LO access classification
    logic isRType;
    logic isMdOp;
    logic isMfOp;
    logic mdBusy;
    logic exStall;
    assign isRType = (opcode == OP_RTYPE);
    assign isMdOp  = isRType && isMulDivFunct(funct);
    assign isMfOp  = isRType && isMoveFromFunct(funct);
    assign exStall = (isMdOp || isMfOp) && mdBusy;

    logic mdStart;
    assign mdStart = isMdOp && !exStall;

    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_unit #(
        .MUL_ITERS (MUL_ITERS),
        .DIV_ITERS (DIV_ITERS)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start    (mdStart),
        .isDiv    ((funct == F_DIV) || (funct == F_DIVU)),
        .isSigned ((funct == F_MULT) || (funct == F_DIV)),
        .opA      (rsData),
        .opB      (rtData),
        .hi       (hi),
        .lo       (lo),
        .busy     (mdBusy)
    );

    // ALU
    logic [31:0] opB;
    logic [31:0] aluResult;
    assign opB = ctrl[CTRL_ALUSRC] ? imm : rtData;

    always_comb begin
        aluResult = 32'd0;
        case (aluOp)
            ALU_ADD: aluResult = rsData + opB;
            ALU_SUB: aluResult = rsData - opB;
            ALU_ORI: aluResult = rsData | {16'd0, imm[15:0]};
            ALU_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU: aluResult = rsData + opB;
                    F_SUB, F_SUBU: aluResult = rsData - opB;
                    F_AND:  aluResult = rsData & opB;
                    F_OR:   aluResult = rsData | opB;
                    F_XOR:  aluResult = rsData ^ opB;
                    F_NOR:  aluResult = ~(rsData | opB);
                    F_SLT:  aluResult = {31'd0, $signed(rsData) < $signed(opB)};
                    F_SLTU: aluResult = {31'd0, rsData < opB};
                    F_SLL:  aluResult = rtData << shamt;
                    F_SRL:  aluResult = rtData >> shamt;
                    F_SRA:  aluResult = $unsigned($signed(rtData) >>> shamt);
                    F_MFHI: aluResult = hi;
                    F_MFLO: aluResult = lo;
                    default: aluResult = 32'd0;
                endcase
            end
            default: aluResult = 32'd0;
        endcase
    end

    // EX/MEM word assembly
    logic [EXME_W-1:0] exmeNext;
    logic [EXME_W-1:0] exmeReg;

    always_comb begin
        exmeNext = '0;
        exmeNext[EX_RESULT_LSB +: 32] = aluResult;
        exmeNext[EX_STORE_LSB +: 32]  = rtData;
        exmeNext[EX_WREG_LSB +: 5]    = ctrl[CTRL_REGDST] ? instr[15:11] : instr[20:16];
        // Multiply/divide results land in HI/LO, never the register file.
        exmeNext[EX_REGWRITE] = ctrl[CTRL_REGWRITE] & ~isMdOp;
        exmeNext[EX_MEMTOREG] = ctrl[CTRL_MEMTOREG];
        exmeNext[EX_MEMWRITE] = ctrl[CTRL_MEMWRITE];
        exmeNext[EX_MEMREAD]  = ctrl[CTRL_MEMREAD];
        exmeNext[EX_ZERO]     = (aluResult == 32'd0);
        exmeNext[EX_VALID]    = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exmeReg <= '0;
        end else if (exStall) begin
            // Instruction is held upstream; emit a bubble.
            exmeReg <= '0;
        end else begin
            exmeReg <= exmeNext;
        end
    end

    assign bus.EXMEReg = exmeReg;
    assign bus.exStall = exStall;
    assign bus.mdBusy  = mdBusy;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage
// Directed vector table, randomized ALU traffic and multiply/divide
// sequences for execute_stage, checked against a behavioural model.
// Build with +define+MULDIV_EARLY_OUT_EN to check the early-out variant.
module tb_execute_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    execute_stage_if bus();

    execute_stage #(.MUL_ITERS(32), .DIV_ITERS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nCmp = 0;
    int nBad = 0;
    logic [31:0] mHi = 32'd0;
    logic [31:0] mLo = 32'd0;

    localparam logic [7:0] C_RTYPE = 8'h91;
    localparam logic [7:0] C_LW    = 8'h63;
    localparam logic [7:0] C_SW    = 8'h06;
    localparam logic [7:0] C_BEQ   = 8'h08;
    localparam logic [7:0] C_ORI   = 8'h1B;

    task automatic check(input string nm, input logic [74:0] act, input logic [74:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [135:0] mk(input logic [7:0] c, input logic [31:0] imm,
                                        input logic [31:0] rt, input logic [31:0] rs,
                                        input logic [31:0] ins);
        return {c, imm, rt, rs, ins};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    // Reference EX/MEM word straight from the instruction semantics.
    function automatic logic [74:0] refEx(input logic [135:0] w, input logic [31:0] hi,
                                          input logic [31:0] lo);
        logic [7:0] c; logic [31:0] imm, rt, rs, ins, b, r; logic [4:0] wr; logic md;
        c = w[135:128]; imm = w[127:96]; rt = w[95:64]; rs = w[63:32]; ins = w[31:0];
        b = c[1] ? imm : rt;
        md = (ins[31:26] == 6'd0) && (ins[5:0] inside {6'h18, 6'h19, 6'h1A, 6'h1B});
        r = 32'd0;
        case (c[4:3])
            2'b00: r = rs + b;
            2'b01: r = rs - b;
            2'b11: r = rs | (imm & 32'h0000_FFFF);
            default: begin
                case (ins[5:0])
                    6'h20, 6'h21: r = rs + b;
                    6'h22, 6'h23: r = rs - b;
                    6'h24: r = rs & b;
                    6'h25: r = rs | b;
                    6'h26: r = rs ^ b;
                    6'h27: r = ~(rs | b);
                    6'h2A: r = ($signed(rs) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: r = (rs < b) ? 32'd1 : 32'd0;
                    6'h00: r = rt << ins[10:6];
                    6'h02: r = rt >> ins[10:6];
                    6'h03: r = $unsigned($signed(rt) >>> ins[10:6]);
                    6'h10: r = hi;
                    6'h12: r = lo;
                    default: r = 32'd0;
                endcase
            end
        endcase
        wr = c[7] ? ins[15:11] : ins[20:16];
        return {1'b1, (r == 32'd0), c[6], c[2], c[5], c[0] & ~md, wr, rt, r};
    endfunction

    // HI/LO results and busy length of a multiply/divide, using 64-bit arithmetic.
    task automatic modelMd(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo, output int it);
        logic [63:0] p; longint sa, sb, q, r; logic [31:0] mag;
        hi = 32'd0; lo = 32'd0; it = 32;
        if (fn == F_MULT || fn == F_MULTU) begin
            if (fn == F_MULT) p = longint'($signed(a)) * longint'($signed(b));
            else              p = {32'd0, a} * {32'd0, b};
            hi = p[63:32]; lo = p[31:0];
`ifdef MULDIV_EARLY_OUT_EN
            mag = (fn == F_MULT && b[31]) ? (32'd0 - b) : b;
            it = 1;
            for (int i = 0; i < 32; i++) if (mag[i]) it = i + 1;
`else
            mag = b;
            it = 32;
`endif
        end else if (b == 32'd0) begin
            hi = a; lo = 32'hFFFF_FFFF; it = 1;
        end else if (fn == F_DIV) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            q = sa / sb; r = sa % sb;
            lo = q[31:0]; hi = r[31:0];
        end else begin
            lo = a / b; hi = a % b;
        end
    endtask

    // Present one instruction and hold it (as upstream would) until accepted.
    task automatic runInstr(input logic [135:0] w, output logic [74:0] ex,
                            output int stalls, output bit bubblesOk);
        bit st; bit done;
        bus.IDEXReg = w; stalls = 0; bubblesOk = 1'b1; done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk); st = bus.exStall;
            @(posedge clk); #1;
            if (st) begin
                stalls++;
                if (bus.EXMEReg !== 75'd0) bubblesOk = 1'b0;
            end else begin
                done = 1'b1;
            end
        end
        ex = bus.EXMEReg;
        if (!done) begin
            nCmp++; nBad++;
            $display("FAIL timeout: instr %h never accepted, stalls %0d expected acceptance", w[31:0], stalls);
        end
        $display("txn instr=%h exme=%h stalls=%0d", w[31:0], ex, stalls);
    endtask

    // Issue a mul/div, then MFLO and MFHI; returns the DUT's LO/HI.
    task automatic doMd(input string nm, input logic [5:0] fn, input logic [31:0] rs,
                        input logic [31:0] rt, output logic [31:0] dLo, output logic [31:0] dHi);
        logic [74:0] ex; int st; bit bOk; logic [31:0] eHi, eLo; int eIt; logic [135:0] w;
        w = mk(C_RTYPE, 32'd0, rt, rs, rtype(5'd4, 5'd5, 5'd6, 5'd0, fn));
        runInstr(w, ex, st, bOk);
        check({nm, " issue valid/regwrite"}, {73'd0, ex[74], ex[69]}, 75'b10);
        check({nm, " busy after issue"}, {74'd0, bus.mdBusy}, 75'd1);
        modelMd(fn, rs, rt, eHi, eLo, eIt);
        mHi = eHi; mLo = eLo;
        w = mk(C_RTYPE, 32'd0, 32'd0, 32'd0, rtype(5'd0, 5'd0, 5'd2, 5'd0, F_MFLO));
        runInstr(w, ex, st, bOk);
        check({nm, " MFLO stall cycles"}, 75'(st), 75'(eIt));
        check({nm, " bubbles while stalled"}, {74'd0, bOk}, 75'd1);
        check({nm, " MFLO word"}, ex, refEx(w, mHi, mLo));
        check({nm, " idle after"}, {74'd0, bus.mdBusy}, 75'd0);
        dLo = ex[31:0];
        w = mk(C_RTYPE, 32'd0, 32'd0, 32'd0, rtype(5'd0, 5'd0, 5'd3, 5'd0, F_MFHI));
        runInstr(w, ex, st, bOk);
        check({nm, " MFHI stall cycles"}, 75'(st), 75'd0);
        check({nm, " MFHI word"}, ex, refEx(w, mHi, mLo));
        dHi = ex[31:0];
    endtask

    typedef struct {
        logic [7:0]  ctrl;
        logic [31:0] imm;
        logic [31:0] rt;
        logic [31:0] rs;
        logic [31:0] instr;
        logic [31:0] res;
        logic [4:0]  wreg;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [74:0] ex; int st; bit bOk; logic [135:0] w; logic [74:0] expw;
        logic [31:0] dLo, dHi, rs, rt, imm, ins; logic [7:0] c; logic [5:0] fn;
        logic [5:0] aluF[16];

        aluF = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h3F};

        vecs[0]  = '{C_RTYPE, 32'd0, 32'd7, 32'd5, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd12, 5'd3};
        vecs[1]  = '{C_LW, 32'hFFFF_FFFC, 32'h55, 32'h100, {6'h23, 5'd1, 5'd9, 16'hFFFC}, 32'hFC, 5'd9};
        vecs[2]  = '{C_BEQ, 32'h10, 32'h77, 32'h77, {6'h04, 5'd1, 5'd2, 16'h0010}, 32'd0, 5'd2};
        vecs[3]  = '{C_ORI, 32'hFFFF_8001, 32'd0, 32'h1234_0000, {6'h0D, 5'd1, 5'd4, 16'h8001}, 32'h1234_8001, 5'd4};
        vecs[4]  = '{C_RTYPE, 32'd0, 32'd1, 32'd0, rtype(5'd1, 5'd2, 5'd5, 5'd0, 6'h22), 32'hFFFF_FFFF, 5'd5};
        vecs[5]  = '{C_RTYPE, 32'd0, 32'hFF00_FF00, 32'hF0F0_F0F0, rtype(5'd1, 5'd2, 5'd6, 5'd0, 6'h24), 32'hF000_F000, 5'd6};
        vecs[6]  = '{C_RTYPE, 32'd0, 32'hFF00_FF00, 32'hF0F0_F0F0, rtype(5'd1, 5'd2, 5'd7, 5'd0, 6'h25), 32'hFFF0_FFF0, 5'd7};
        vecs[7]  = '{C_RTYPE, 32'd0, 32'hFF00_FF00, 32'hF0F0_F0F0, rtype(5'd1, 5'd2, 5'd8, 5'd0, 6'h26), 32'h0FF0_0FF0, 5'd8};
        vecs[8]  = '{C_RTYPE, 32'd0, 32'hFF00_FF00, 32'hF0F0_F0F0, rtype(5'd1, 5'd2, 5'd9, 5'd0, 6'h27), 32'h000F_000F, 5'd9};
        vecs[9]  = '{C_RTYPE, 32'd0, 32'd1, 32'hFFFF_FFFF, rtype(5'd1, 5'd2, 5'd10, 5'd0, 6'h2A), 32'd1, 5'd10};
        vecs[10] = '{C_RTYPE, 32'd0, 32'd1, 32'hFFFF_FFFF, rtype(5'd1, 5'd2, 5'd11, 5'd0, 6'h2B), 32'd0, 5'd11};
        vecs[11] = '{C_RTYPE, 32'd0, 32'd1, 32'h999, rtype(5'd1, 5'd2, 5'd12, 5'd4, 6'h00), 32'd16, 5'd12};
        vecs[12] = '{C_RTYPE, 32'd0, 32'h8000_0000, 32'd0, rtype(5'd1, 5'd2, 5'd13, 5'd4, 6'h02), 32'h0800_0000, 5'd13};
        vecs[13] = '{C_RTYPE, 32'd0, 32'h8000_0000, 32'd0, rtype(5'd1, 5'd2, 5'd14, 5'd4, 6'h03), 32'hF800_0000, 5'd14};
        vecs[14] = '{C_RTYPE, 32'd0, 32'd5, 32'd5, rtype(5'd1, 5'd2, 5'd15, 5'd0, 6'h3F), 32'd0, 5'd15};
        vecs[15] = '{C_SW, 32'd8, 32'hDEAD_BEEF, 32'h1000, {6'h2B, 5'd1, 5'd3, 16'h0008}, 32'h1008, 5'd3};

        // Reset state
        bus.IDEXReg = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset EXMEReg", bus.EXMEReg, 75'd0);
        check("reset mdBusy", {74'd0, bus.mdBusy}, 75'd0);
        check("reset exStall", {74'd0, bus.exStall}, 75'd0);
        @(negedge clk); rst = 1'b0;

        // Directed table
        for (int i = 0; i < 16; i++) begin
            w = mk(vecs[i].ctrl, vecs[i].imm, vecs[i].rt, vecs[i].rs, vecs[i].instr);
            runInstr(w, ex, st, bOk);
            c = vecs[i].ctrl;
            expw = {1'b1, (vecs[i].res == 32'd0), c[6], c[2], c[5], c[0], vecs[i].wreg, vecs[i].rt, vecs[i].res};
            check($sformatf("vec%0d word", i), ex, expw);
            check($sformatf("vec%0d stalls", i), 75'(st), 75'd0);
        end

        // Randomized ALU traffic against the model (engine idle, HI/LO = 0)
        for (int i = 0; i < 150; i++) begin
            rs = $urandom; rt = $urandom; imm = $urandom; c = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin rs = 32'($urandom_range(0, 3)); rt = rs; end
            if ($urandom_range(0, 1) == 0) begin
                fn = aluF[$urandom_range(0, 15)];
                c[4:3] = 2'b10;
                ins = {6'd0, 20'($urandom), fn};
            end else begin
                case ($urandom_range(0, 2))
                    0: c[4:3] = 2'b00;
                    1: c[4:3] = 2'b01;
                    default: c[4:3] = 2'b11;
                endcase
                ins = {6'h23, 26'($urandom)};
            end
            w = mk(c, imm, rt, rs, ins);
            runInstr(w, ex, st, bOk);
            check($sformatf("rnd%0d word", i), ex, refEx(w, mHi, mLo));
        end

        // Multiply/divide sequences from the plan
        doMd("MULT -2x3", F_MULT, 32'hFFFF_FFFE, 32'd3, dLo, dHi);
        check("MULT lo", 75'(dLo), 75'h0_FFFF_FFFA);
        check("MULT hi", 75'(dHi), 75'h0_FFFF_FFFF);
        doMd("DIVU 100/7", F_DIVU, 32'd100, 32'd7, dLo, dHi);
        check("DIVU lo", 75'(dLo), 75'd14);
        check("DIVU hi", 75'(dHi), 75'd2);
        doMd("DIV -7/2", F_DIV, 32'hFFFF_FFF9, 32'd2, dLo, dHi);
        check("DIV lo", 75'(dLo), 75'h0_FFFF_FFFD);
        check("DIV hi", 75'(dHi), 75'h0_FFFF_FFFF);
        doMd("DIV by zero", F_DIV, 32'h55, 32'd0, dLo, dHi);
        check("DIV0 lo", 75'(dLo), 75'h0_FFFF_FFFF);
        check("DIV0 hi", 75'(dHi), 75'h55);
        doMd("MULTU 5x3", F_MULTU, 32'd5, 32'd3, dLo, dHi);
        check("MULTU lo", 75'(dLo), 75'd15);

        // Non-muldiv instruction flows while the engine is busy
        w = mk(C_RTYPE, 32'd0, 32'h9ABC_DEF0, 32'h1234_5678, rtype(5'd4, 5'd5, 5'd6, 5'd0, F_MULTU));
        runInstr(w, ex, st, bOk);
        modelMd(F_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, mHi, mLo, st);
        w = mk(C_RTYPE, 32'd0, 32'd40, 32'd2, rtype(5'd1, 5'd2, 5'd7, 5'd0, F_ADD));
        runInstr(w, ex, st, bOk);
        check("add during busy stalls", 75'(st), 75'd0);
        check("add during busy word", ex, refEx(w, mHi, mLo));
        w = mk(C_RTYPE, 32'd0, 32'd0, 32'd0, rtype(5'd0, 5'd0, 5'd2, 5'd0, F_MFLO));
        runInstr(w, ex, st, bOk);
        check("MFLO after add stalls", 75'(st), 75'd31);
        check("MFLO after add word", ex, refEx(w, mHi, mLo));

        // Random multiply/divide operations
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 3))
                0: fn = F_MULT;
                1: fn = F_MULTU;
                2: fn = F_DIV;
                default: fn = F_DIVU;
            endcase
            rs = $urandom;
            case ($urandom_range(0, 2))
                0: rt = 32'($urandom_range(0, 7));
                1: rt = 32'($urandom_range(0, 32'hFFFF));
                default: rt = $urandom;
            endcase
            doMd($sformatf("rndmd%0d", i), fn, rs, rt, dLo, dHi);
        end

        // Reset during the 10th multiply iteration
        w = mk(C_RTYPE, 32'd0, 32'hFFFF_0000, 32'h1234, rtype(5'd1, 5'd2, 5'd0, 5'd0, F_MULT));
        runInstr(w, ex, st, bOk);
        bus.IDEXReg = '0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("busy before reset", {74'd0, bus.mdBusy}, 75'd1);
        rst = 1'b1;
        #1;
        check("mid-op reset EXMEReg", bus.EXMEReg, 75'd0);
        check("mid-op reset mdBusy", {74'd0, bus.mdBusy}, 75'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mHi = 32'd0; mLo = 32'd0;
        w = mk(C_RTYPE, 32'd0, 32'd0, 32'd0, rtype(5'd0, 5'd0, 5'd2, 5'd0, F_MFLO));
        runInstr(w, ex, st, bOk);
        check("MFLO after reset stalls", 75'(st), 75'd0);
        check("MFLO after reset word", ex, refEx(w, mHi, mLo));
        check("MFLO after reset value", 75'(ex[31:0]), 75'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
